hangman_progress: RTL and testbench
===================================

Name: hangman_progress

Overview:
- Game-state datapath downstream of the letter-match controller (`control_letter`).
- Consumes the per-position match enables for each committed guess and accumulates the revealed-position mask.
- Tracks the set of already-guessed letters and counts wrong guesses.
- Declares win or loss; outputs feed the HEX and LED display logic.

Parameters:
- NUM_POS, 5, number of letter positions; bit i maps to enable_l(i+1).
- MAX_WRONG, 6, wrong guesses that end the game; legal range 1..15.
- LETTER_W, 5, letter code width; codes 0..25 = A..Z.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- new_game  in  1  one-cycle pulse; clears game state.
- word_mask  in  NUM_POS  1 = real letter position, 0 = dummy slot; held stable during a game.
- guess_valid  in  1  one-cycle pulse; guess and match are valid this cycle.
- guess  in  LETTER_W  letter code of the committed guess.
- match  in  NUM_POS  position enables from the controller, aligned with guess_valid.
- revealed  out  NUM_POS  positions guessed correctly.
- wrong_count  out  4  wrong guesses so far.
- used_letters  out  26  bit k set = letter k already guessed.
- dup_guess  out  1  one-cycle pulse: repeated letter, ignored.
- bad_guess  out  1  one-cycle pulse: code above 25, ignored.
- game_won  out  1  high in WON.
- game_lost  out  1  high in LOST.
- lives_led  out  10  lives bar (see Optional Feature).

Behaviour:
- All state changes on the rising clk edge. resetn==0 at an edge forces:
  - state = PLAY;
  - revealed = 0, wrong_count = 0, used_letters = 0;
  - dup_guess = 0, bad_guess = 0, game_won = 0, game_lost = 0, lives_led = 0.
- resetn has priority over every other input.
- FSM states: PLAY, WON, LOST. game_won and game_lost are decoded from state.
- new_game=1 (resetn=1):
  - Same clears as reset; next state PLAY, from any state.
  - A guess_valid in the same cycle is dropped; no pulses.
- PLAY with guess_valid=1. Latency: 1 cycle; outputs reflect the guess on the cycle after the sampling edge. Cases are evaluated in this order:
  - guess > 25: bad_guess=1 for one cycle. No other change.
  - used_letters[guess]==1: dup_guess=1 for one cycle. No other change.
  - Otherwise used_letters[guess] is set, and hit = match & word_mask.
    - hit != 0: revealed |= hit.
    - hit == 0: wrong_count += 1.
- Win check, evaluated on next-state values in the same edge:
  - If word_mask != 0 and (revealed_next & word_mask) == word_mask, go to WON.
  - Else if wrong_count_next == MAX_WRONG, go to LOST.
  - The two cannot coincide. Win is checked first.
- Match bits in dummy positions (word_mask=0) are discarded. They never reveal and never count as a hit.
- word_mask == 0: the game is unwinnable; every new valid guess is wrong.
- wrong_count never exceeds MAX_WRONG and never wraps.
- WON / LOST:
  - guess_valid is ignored entirely: no pulses, no register change.
  - State is held until new_game or reset.
- guess_valid with match != 0 for a duplicate letter: still a duplicate. revealed is unchanged.
- dup_guess and bad_guess are registered. They are 0 in every cycle not immediately following a qualifying guess.

Optional Feature:
- Macro: HANGMAN_LED_LIVES_EN.
- Defined: lives_led is a thermometer code with the low (MAX_WRONG − wrong_count) bits set; the remaining bits are 0.
  - Registered, same timing as wrong_count.
  - Forced to 0 in WON.
  - 0 in LOST, since lives are exhausted.
  - MAX_WRONG above 10 saturates at 10 bits set.
- Not defined: lives_led is constant 0. No lives logic is synthesized.

Test Plan:
- Word STAY (S=18, T=19, A=0, Y=24), word_mask=01111, MAX_WRONG=6. Guesses 18/match=00001, 19/00010, 0/00100, 24/01000 → revealed steps 0001→0011→0111→1111; game_won=1 one cycle after the 4th guess; wrong_count=0.
- Same word, guesses 1,2,3,4,5,6 with match=0 → wrong_count 1..6; game_lost=1 after the 6th; a 7th guess leaves wrong_count=6 with no pulse.
- Guess 18/00001 twice → second guess gives dup_guess=1 for exactly one cycle; revealed=00001 and wrong_count=0 unchanged. Guess 30 → bad_guess=1; used_letters unchanged.
- match=10000 with word_mask=01111, guess 7 → revealed unchanged; wrong_count=1; used_letters[7]=1.
- Mid-game (revealed=00011, wrong_count=2), assert new_game together with guess_valid → next cycle revealed=0, wrong_count=0, used_letters=0, no pulses. Drop resetn in WON → PLAY with all outputs 0.
- With HANGMAN_LED_LIVES_EN, MAX_WRONG=6, after 2 wrong guesses → lives_led=0000001111; with the macro undefined → lives_led=0 throughout.

Source files
------------

// File: rtl/hangman_progress.sv
// hangman_progress: game-state datapath after control_letter.
// Accumulates revealed positions, used letters, wrong guesses;
// decodes win/loss for the HEX/LED display logic.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   new_game         pulse, clears game state (drops same-cycle guess)
//   word_mask        1 = real letter position, 0 = dummy slot
//   guess_valid      pulse, guess/match valid this cycle
//   guess, match     letter code and per-position enables
//   revealed         positions guessed correctly
//   wrong_count      wrong guesses so far (saturates at MAX_WRONG)
//   used_letters     bit k = letter k already guessed
//   dup_guess        pulse, repeated letter ignored
//   bad_guess        pulse, code above 25 ignored
//   game_won/lost    decoded from state
//   lives_led        lives bar, only with HANGMAN_LED_LIVES_EN defined
//
// Optional: `define HANGMAN_LED_LIVES_EN for the thermometer lives bar.
module hangman_progress #(
  parameter int NUM_POS   = 5,
  parameter int MAX_WRONG = 6,
  parameter int LETTER_W  = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                new_game,
  input  logic [NUM_POS-1:0]  word_mask,
  input  logic                guess_valid,
  input  logic [LETTER_W-1:0] guess,
  input  logic [NUM_POS-1:0]  match,
  output logic [NUM_POS-1:0]  revealed,
  output logic [3:0]          wrong_count,
  output logic [25:0]         used_letters,
  output logic                dup_guess,
  output logic                bad_guess,
  output logic                game_won,
  output logic                game_lost,
  output logic [9:0]          lives_led
);

  localparam logic [1:0] S_PLAY = 2'd0;
  localparam logic [1:0] S_WON  = 2'd1;
  localparam logic [1:0] S_LOST = 2'd2;

  localparam logic [3:0] WMAX = 4'(MAX_WRONG);

  logic [1:0]         state, state_n;
  logic [NUM_POS-1:0] hit, rev_n;
  logic [3:0]         wc_n;
  logic [25:0]        used_n, letter_oh;
  logic               dup_n, bad_n;
  logic               take, is_bad, is_dup, win;

  always_comb begin
    is_bad    = guess > LETTER_W'(25);
    // codes above 25 shift out of the vector, so is_dup stays 0
    letter_oh = 26'(1) << guess;
    is_dup    = |(used_letters & letter_oh);
    take      = guess_valid && (state == S_PLAY);
    // dummy slots never reveal and never count as a hit
    hit       = match & word_mask;
    rev_n     = revealed;
    wc_n      = wrong_count;
    used_n    = used_letters;
    dup_n     = 1'b0;
    bad_n     = 1'b0;
    if (take) begin
      unique case (1'b1)
        is_bad: bad_n = 1'b1;
        is_dup: dup_n = 1'b1;
        default: begin
          used_n = used_letters | letter_oh;
          if (|hit)
            rev_n = revealed | hit;
          else if (wrong_count < WMAX)
            wc_n = wrong_count + 4'd1;
        end
      endcase
    end
    win     = (|word_mask) &&
              ((rev_n & word_mask) == word_mask);
    state_n = state;
    if (state == S_PLAY) begin
      if (win)
        state_n = S_WON;
      else if (wc_n == WMAX)
        state_n = S_LOST;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || new_game) begin
      state        <= S_PLAY;
      revealed     <= '0;
      wrong_count  <= '0;
      used_letters <= '0;
      dup_guess    <= 1'b0;
      bad_guess    <= 1'b0;
    end else begin
      state        <= state_n;
      revealed     <= rev_n;
      wrong_count  <= wc_n;
      used_letters <= used_n;
      dup_guess    <= dup_n;
      bad_guess    <= bad_n;
    end
  end

  assign game_won  = (state == S_WON);
  assign game_lost = (state == S_LOST);

`ifdef HANGMAN_LED_LIVES_EN
  logic [3:0]  left;
  logic [10:0] therm;
  logic [9:0]  lives_n;

  always_comb begin
    left = WMAX - wc_n;
    if (left > 4'd10)
      left = 4'd10;
    therm   = (11'(1) << left) - 11'd1;
    lives_n = therm[9:0];
    // bar is dark once the game is over
    if (state_n != S_PLAY)
      lives_n = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn || new_game)
      lives_led <= '0;
    else
      lives_led <= lives_n;
  end
`else
  assign lives_led = '0;
`endif

endmodule

// File: tb/tb_hangman_progress.sv
// tb_hangman_progress: directed self-checking bench.
module tb_hangman_progress;

  logic       clk = 1'b0;
  logic       resetn;
  logic       new_game;
  logic [4:0] word_mask;
  logic       guess_valid;
  logic [4:0] guess;
  logic [4:0] match;
  logic [4:0] revealed;
  logic [3:0] wrong_count;
  logic [25:0] used_letters;
  logic       dup_guess;
  logic       bad_guess;
  logic       game_won;
  logic       game_lost;
  logic [9:0] lives_led;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  hangman_progress dut (
    .clk          (clk),
    .resetn       (resetn),
    .new_game     (new_game),
    .word_mask    (word_mask),
    .guess_valid  (guess_valid),
    .guess        (guess),
    .match        (match),
    .revealed     (revealed),
    .wrong_count  (wrong_count),
    .used_letters (used_letters),
    .dup_guess    (dup_guess),
    .bad_guess    (bad_guess),
    .game_won     (game_won),
    .game_lost    (game_lost),
    .lives_led    (lives_led)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    guess_valid = 1'b0;
    new_game    = 1'b0;
    match       = '0;
  endtask

  task automatic play(input logic [4:0] g,
                      input logic [4:0] m);
    @(negedge clk);
    guess_valid = 1'b1;
    guess       = g;
    match       = m;
    step();
  endtask

  task automatic idle();
    @(negedge clk);
    step();
  endtask

  task automatic restart();
    @(negedge clk);
    new_game = 1'b1;
    step();
  endtask

  initial begin
    logic [9:0] lives2;
`ifdef HANGMAN_LED_LIVES_EN
    lives2 = 10'b0000001111;
`else
    lives2 = 10'b0;
`endif
    resetn      = 1'b0;
    new_game    = 1'b0;
    word_mask   = 5'b01111;
    guess_valid = 1'b0;
    guess       = '0;
    match       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rev",  32'(revealed), 0);
    chk("rst_wc",   32'(wrong_count), 0);
    chk("rst_used", 32'(used_letters), 0);
    chk("rst_won",  32'(game_won), 0);
    chk("rst_lost", 32'(game_lost), 0);
    chk("rst_dup",  32'(dup_guess), 0);
    chk("rst_bad",  32'(bad_guess), 0);
    chk("rst_led",  32'(lives_led), 0);
    @(negedge clk);
    resetn = 1'b1;

    // STAY win
    play(5'd18, 5'b00001);
    chk("w1_rev", 32'(revealed), 32'b00001);
    chk("w1_won", 32'(game_won), 0);
    play(5'd19, 5'b00010);
    chk("w2_rev", 32'(revealed), 32'b00011);
    play(5'd0, 5'b00100);
    chk("w3_rev", 32'(revealed), 32'b00111);
    chk("w3_won", 32'(game_won), 0);
    play(5'd24, 5'b01000);
    chk("w4_rev", 32'(revealed), 32'b01111);
    chk("w4_won", 32'(game_won), 1);
    chk("w4_wc",  32'(wrong_count), 0);
    chk("w4_used", 32'(used_letters),
        32'h1000000 | 32'h80000 | 32'h40000 | 32'h1);
    play(5'd18, 5'b00001);
    chk("won_nodup", 32'(dup_guess), 0);
    chk("won_hold",  32'(game_won), 1);
    chk("won_led",   32'(lives_led), 0);

    // loss
    restart();
    chk("ng_won", 32'(game_won), 0);
    for (int i = 1; i <= 6; i++) begin
      play(5'(i), 5'b0);
      chk($sformatf("l%0d_wc", i),
          32'(wrong_count), 32'(i));
      if (i == 2)
        chk("l2_led", 32'(lives_led), 32'(lives2));
      chk($sformatf("l%0d_lost", i),
          32'(game_lost), (i == 6) ? 1 : 0);
    end
    chk("l6_led", 32'(lives_led), 0);
    play(5'd7, 5'b0);
    chk("l7_wc",   32'(wrong_count), 6);
    chk("l7_dup",  32'(dup_guess), 0);
    chk("l7_bad",  32'(bad_guess), 0);
    chk("l7_lost", 32'(game_lost), 1);

    // duplicate and bad code
    restart();
    play(5'd18, 5'b00001);
    chk("d1_dup", 32'(dup_guess), 0);
    play(5'd18, 5'b00001);
    chk("d2_dup", 32'(dup_guess), 1);
    chk("d2_rev", 32'(revealed), 32'b00001);
    chk("d2_wc",  32'(wrong_count), 0);
    idle();
    chk("d3_dup", 32'(dup_guess), 0);
    play(5'd30, 5'b00001);
    chk("b_bad",  32'(bad_guess), 1);
    chk("b_used", 32'(used_letters), 32'h40000);
    chk("b_rev",  32'(revealed), 32'b00001);
    idle();
    chk("b2_bad", 32'(bad_guess), 0);

    // match in dummy slot
    play(5'd7, 5'b10000);
    chk("dm_rev",  32'(revealed), 32'b00001);
    chk("dm_wc",   32'(wrong_count), 1);
    chk("dm_used", 32'(used_letters[7]), 1);

    // new_game with simultaneous guess
    play(5'd19, 5'b00010);
    play(5'd8, 5'b0);
    chk("mg_rev", 32'(revealed), 32'b00011);
    chk("mg_wc",  32'(wrong_count), 2);
    @(negedge clk);
    new_game    = 1'b1;
    guess_valid = 1'b1;
    guess       = 5'd0;
    match       = 5'b00100;
    step();
    chk("ng_rev",  32'(revealed), 0);
    chk("ng_wc",   32'(wrong_count), 0);
    chk("ng_used", 32'(used_letters), 0);
    chk("ng_dup",  32'(dup_guess), 0);
    chk("ng_bad",  32'(bad_guess), 0);

    // empty word is unwinnable
    word_mask = 5'b0;
    play(5'd0, 5'b00001);
    chk("z_rev", 32'(revealed), 0);
    chk("z_wc",  32'(wrong_count), 1);
    chk("z_won", 32'(game_won), 0);

    // reset out of WON
    restart();
    word_mask = 5'b00001;
    play(5'd5, 5'b00001);
    chk("r_won", 32'(game_won), 1);
    @(negedge clk);
    resetn = 1'b0;
    step();
    chk("r2_won",  32'(game_won), 0);
    chk("r2_lost", 32'(game_lost), 0);
    chk("r2_rev",  32'(revealed), 0);
    chk("r2_used", 32'(used_letters), 0);
    chk("r2_led",  32'(lives_led), 0);

    $display("test done: total=%0d bad=%0d",
             n_total, n_bad);
    $finish;
  end

endmodule
